// File: rtl/instr_sequencer_pkg.sv
// Shared constants for the instruction sequencer: FSM states, opcodes, ALU
// operation codes and register-field helpers.
package instr_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_ADDI = 4'd3,
    OP_MOVI = 4'd4,
    OP_HALT = 4'd15
  } opcode_t;

  typedef enum logic [2:0] {
    ALU_PASS_B = 3'd0,
    ALU_ADD    = 3'd1,
    ALU_SUB    = 3'd2
  } alu_op_t;

  // Register fields name reg1..reg4; anything else is an illegal reference.
  function automatic logic reg_ok(input logic [7:0] f);
    return (f >= 8'd1) && (f <= 8'd4);
  endfunction

  function automatic logic [1:0] reg_idx(input logic [7:0] f);
    logic [7:0] t;
    t = f - 8'd1;
    return t[1:0];
  endfunction

endpackage

// File: rtl/instr_sequencer_decode.sv
// Combinational decode of the latched instruction word into register selects,
// ALU control and write/illegal/halt qualifiers.
module instr_field_decode
  import instr_sequencer_pkg::*;
(
  input  logic [19:0] ir,
  output logic [1:0]  rd_a_sel,
  output logic [1:0]  rd_b_sel,
  output logic [1:0]  wr_sel,
  output logic [2:0]  alu_op,
  output logic        imm_sel,
  output logic        we,
  output logic        arith,
  output logic        illegal,
  output logic        halt
);

  logic [3:0] op;
  logic [7:0] fa;
  logic [7:0] fb;

  assign op = ir[19:16];
  assign fa = ir[15:8];
  assign fb = ir[7:0];

  always_comb begin
    rd_a_sel = '0;
    rd_b_sel = '0;
    wr_sel   = '0;
    alu_op   = ALU_PASS_B;
    imm_sel  = 1'b0;
    we       = 1'b0;
    arith    = 1'b0;
    illegal  = 1'b0;
    halt     = 1'b0;
    case (op)
      OP_NOP: ;
      OP_ADD, OP_SUB: begin
        if (reg_ok(fa) && reg_ok(fb)) begin
          rd_a_sel = reg_idx(fa);
          rd_b_sel = reg_idx(fb);
          wr_sel   = reg_idx(fa);
          alu_op   = (op == OP_ADD) ? ALU_ADD : ALU_SUB;
          we       = 1'b1;
          arith    = 1'b1;
        end else begin
          illegal  = 1'b1;
        end
      end
      OP_ADDI: begin
        if (reg_ok(fa)) begin
          rd_a_sel = reg_idx(fa);
          wr_sel   = reg_idx(fa);
          alu_op   = ALU_ADD;
          imm_sel  = 1'b1;
          we       = 1'b1;
          arith    = 1'b1;
        end else begin
          illegal  = 1'b1;
        end
      end
      OP_MOVI: begin
        if (reg_ok(fa)) begin
          wr_sel   = reg_idx(fa);
          alu_op   = ALU_PASS_B;
          imm_sel  = 1'b1;
          we       = 1'b1;
        end else begin
          illegal  = 1'b1;
        end
      end
      OP_HALT: halt = 1'b1;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// Four-cycle multi-cycle instruction sequencer: FETCH/DECODE/EXEC/WB around an
// external register file and ALU, with sticky status flags and a retire count.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [19:0]      instruction,
  input  logic [8:0]       alu_result,
  output logic             pc_hold,
  output logic             rf_we,
  output logic [1:0]       rd_a_sel,
  output logic [1:0]       rd_b_sel,
  output logic [1:0]       wr_sel,
  output logic             imm_sel,
  output logic [7:0]       imm,
  output logic [2:0]       alu_op,
  output logic [7:0]       wr_data,
  output logic             busy,
  output logic             halted,
  output logic             ovf_flag,
  output logic             illegal_flag,
  output logic [CNT_W-1:0] retired
);

  state_t     state;
  state_t     state_nxt;
  logic [19:0] ir;
  logic [8:0]  alu_cap;
  logic        d_we;
  logic        d_arith;
  logic        d_illegal;
  logic        d_halt;

  instr_field_decode u_decode (
    .ir       (ir),
    .rd_a_sel (rd_a_sel),
    .rd_b_sel (rd_b_sel),
    .wr_sel   (wr_sel),
    .alu_op   (alu_op),
    .imm_sel  (imm_sel),
    .we       (d_we),
    .arith    (d_arith),
    .illegal  (d_illegal),
    .halt     (d_halt)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = FETCH;
      FETCH:   state_nxt = DECODE;
      DECODE:  state_nxt = d_halt ? HALT : EXEC;
      EXEC:    state_nxt = WB;
      WB:      state_nxt = FETCH;
      HALT:    state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      ir           <= '0;
      alu_cap      <= '0;
      ovf_flag     <= 1'b0;
      illegal_flag <= 1'b0;
      retired      <= '0;
    end else begin
      state <= state_nxt;
      if (state == FETCH) ir <= instruction;
      if (state == EXEC) alu_cap <= alu_result;
      if (state == WB) begin
        // A 9-bit sign-extended result whose top two bits differ left the 8-bit range.
        if (d_arith && (alu_cap[8] != alu_cap[7])) ovf_flag <= 1'b1;
        if (d_illegal) illegal_flag <= 1'b1;
        if (retired != '1) retired <= retired + 1'b1;
      end
    end
  end

  // Reset suppresses the strobe combinationally so an aborted WB never writes.
  assign rf_we   = (state == WB) && d_we && !reset;
  assign pc_hold = (state != WB);
  assign busy    = (state == FETCH) || (state == DECODE) || (state == EXEC) || (state == WB);
  assign halted  = (state == HALT);
  assign imm     = ir[7:0];
  assign wr_data = alu_cap[7:0];

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have parameter: CNT_W, 16, width of retired-instruction counter.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  one-cycle pulse; begins execution from IDLE.
REQ-005 SHALL have port: instruction  input  20  [19:16] opcode, [15:8] first_num, [7:0] second_num.
REQ-006 SHALL have port: alu_result  input  9  combinational ALU output for current selects.
REQ-007 SHALL have ports: pc_hold  output  1  0 advances PC one slot; rf_we  output  1  register write strobe.
REQ-008 SHALL have ports: rd_a_sel, rd_b_sel, wr_sel  output  2 each  register index minus 1 (reg1=0..reg4=3).
REQ-009 SHALL have ports: imm_sel  output  1  operand B = immediate; imm  output  8  second_num; alu_op  output  3.
REQ-010 SHALL have ports: wr_data  output  8  write-back value; busy, halted, ovf_flag, illegal_flag  output  1 each; retired  output  CNT_W.

Function
REQ-011 SHALL implement FSM states IDLE, FETCH, DECODE, EXEC, WB, HALT.
REQ-012 SHALL go IDLE->FETCH on start; DECODE->HALT on OP_HALT; otherwise FETCH->DECODE->EXEC->WB->FETCH, giving 4 cycles per instruction.
REQ-013 SHALL latch instruction into internal IR at end of FETCH; instruction is ignored in every other state.
REQ-014 SHALL decode opcodes: 0 NOP; 1 ADD rA=rA+rB; 2 SUB rA=rA-rB; 3 ADDI rA=rA+imm; 4 MOVI rA=imm; 15 HALT; all others illegal. rA=first_num, rB=second_num.
REQ-015 SHALL treat as illegal any register field outside 1..4 that the opcode uses.
REQ-016 SHALL drive alu_op PASS_B(0) for MOVI, ADD(1) for ADD/ADDI, SUB(2) for SUB; imm_sel=1 for ADDI/MOVI; hold selects stable from DECODE through WB.
REQ-017 SHALL capture alu_result at end of EXEC; wr_data = captured[7:0].
REQ-018 SHALL set sticky ovf_flag in WB when ADD/SUB/ADDI and captured[8] != captured[7]; write still occurs (wrap, no saturation).
REQ-019 SHALL assert rf_we for exactly the WB cycle, only for ADD/SUB/ADDI/MOVI with legal fields.
REQ-020 SHALL deassert pc_hold only in the WB cycle (including NOP and illegal); pc_hold=1 in all other states.
REQ-021 SHALL set sticky illegal_flag in WB for illegal instructions, with no register write.
REQ-022 SHALL increment retired in every WB cycle, saturating at all-ones.
REQ-023 SHALL hold busy=1 in FETCH, DECODE, EXEC, WB; halted=1 only in HALT.
REQ-024 SHALL ignore start when not in IDLE; HALT is left only by reset.

Reset
REQ-025 SHALL, on reset (reset wins over start), enter IDLE; pc_hold=1; rf_we, busy, halted, ovf_flag, illegal_flag, imm_sel=0; selects, alu_op, imm, wr_data, IR=0; retired=0.
REQ-026 SHALL abort an in-flight instruction on reset with no rf_we in the reset cycle or the next cycle.

Structure
REQ-027 SHALL take opcode values, ALU op codes, and state encodings from the shared define_vars constants file.
REQ-028 SHALL place decode in one combinational sub-module, instr_field_decode (IR in; selects, alu_op, imm_sel, write-enable, illegal, halt out).

Verification
REQ-029 SHALL verify: reset, start, MOVI r1,5 -> rf_we in cycle 4 after FETCH entry, wr_sel=0, wr_data=5, retired=1.
REQ-030 SHALL verify: ADD r1,r2 with alu_result=9'h0A0 (100+60) -> wr_data=8'hA0, ovf_flag=1.
REQ-031 SHALL verify: opcode 7, then ADD r5,r1 -> no rf_we, illegal_flag=1, pc_hold low once per instruction, retired=2.
REQ-032 SHALL verify: HALT -> halted=1, busy=0, pc_hold=1, start ignored for 10 cycles, retired unchanged.
REQ-033 SHALL verify: reset asserted during EXEC of ADDI r3,-1 -> next cycle IDLE, no rf_we, all flags 0.
REQ-034 SHALL verify: start and reset in same cycle -> IDLE; start pulse during busy -> no effect on sequence.
